// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register file and its consumers.
//   DEF_DW / DEF_DEPTH / DEF_NRD : default data width, depth, read-port count
//   reset_value(idx, dw)         : power-on contents of register idx
//   port_lsb(port, width)        : LSB of port slot in a packed multi-port bus
//   addr_ok(addr, depth)         : address names a real, writable register
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NRD   = 2;

    // Registers come out of reset holding their own index (mod 2^dw), so a
    // freshly reset datapath can be sanity-checked by simply reading back.
    function automatic int unsigned reset_value(input int unsigned idx,
                                                input int unsigned dw);
        if (dw >= 32)
            return idx;
        return idx % (32'd1 << dw);
    endfunction

    // Packed ports are laid out port 0 in the low bits; slot p starts here.
    function automatic int unsigned port_lsb(input int unsigned port,
                                             input int unsigned width);
        return port * width;
    endfunction

    // Register 0 is hardwired and depth need not be a power of two, so both
    // zero and addresses past the last register are treated as "no register".
    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned depth);
        return (addr != 0) && (addr < depth);
    endfunction

endpackage

// File: rtl/reg_file_param_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits used by issue logic for RAW hazard detection.
//   clk, rst           : clock (rising edge), async active-high reset
//   wr_en, wr_addr     : completed write, clears the destination busy bit
//   rsv_en, rsv_addr   : reservation, sets the destination busy bit
//   rd_addr            : packed read addresses, NRD slots of AW bits
//   port_busy          : combinational pre-edge busy bit for each read port
//   busy_any           : registered OR of the busy vector after the edge
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    port_busy,
    output logic              busy_any
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // The reservation is applied after the clear so that a same-cycle write
    // and reserve leave the register pending for the newer producer.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && addr_ok(32'(wr_addr), DEPTH))
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_en && addr_ok(32'(rsv_addr), DEPTH))
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_any <= |busy_nxt;
        end
    end

    // Lookup uses the pre-edge vector: a read racing a reserve sees "free".
    for (genvar g = 0; g < NRD; g++) begin : g_lookup
        logic [AW-1:0] addr;
        assign addr         = rd_addr[port_lsb(g, AW) +: AW];
        assign port_busy[g] = addr_ok(32'(addr), DEPTH) ? busy[addr] : 1'b0;
    end

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised register file: DEPTH x DW registers, NRD registered read
// ports, one write port, and a busy scoreboard for RAW hazard detection.
// Register 0 reads as zero and ignores writes.
//   clk, rst           : clock (rising edge), async active-high reset
//   wr_en/addr/data    : write port
//   rd_en              : per-port read strobe (outputs hold when low)
//   rd_addr            : packed read addresses, port p at [p*AW +: AW]
//   rd_data            : packed registered read data, port p at [p*DW +: DW]
//   rd_busy            : registered busy flag of the register read per port
//   rsv_en, rsv_addr   : mark a destination register as pending
//   busy_any           : registered OR of all busy bits
// Build option: define REGFILE_BYPASS_EN to forward a same-edge write to
// reads of the written address; otherwise such reads see the old contents.
// ---------------------------------------------------------------------------
module reg_file_param
    import regfile_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic              busy_any
);

    logic [DW-1:0]  regs      [DEPTH];
    logic [AW-1:0]  port_addr [NRD];
    logic [DW-1:0]  rd_mux    [NRD];
    logic [NRD-1:0] rd_busy_mux;
    logic [NRD-1:0] sb_busy;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .port_busy (sb_busy),
        .busy_any  (busy_any)
    );

    for (genvar g = 0; g < NRD; g++) begin : g_addr
        assign port_addr[g] = rd_addr[port_lsb(g, AW) +: AW];
    end

    // Data array. Entry 0 is never written, so it stays at its reset value 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= DW'(reset_value(i, DW));
        end else if (wr_en && addr_ok(32'(wr_addr), DEPTH)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Per-port read selection. With bypass, a same-edge write wins over the
    // array; its busy bit reads as 0 because the write retires the producer,
    // unless a reserve to the same register in this cycle re-arms it, in
    // which case the pre-edge busy value is reported.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_mux[p]      = '0;
            rd_busy_mux[p] = 1'b0;
            if (addr_ok(32'(port_addr[p]), DEPTH)) begin
                rd_mux[p]      = regs[port_addr[p]];
                rd_busy_mux[p] = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == port_addr[p])) begin
                    rd_mux[p] = wr_data;
                    if (!(rsv_en && (rsv_addr == port_addr[p])))
                        rd_busy_mux[p] = 1'b0;
                end
`endif
            end
        end
    end

    // Registered read outputs; a port without rd_en keeps its last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data[port_lsb(p, DW) +: DW] <= rd_mux[p];
                    rd_busy[p]                     <= rd_busy_mux[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Drives two instances from shared write/reserve inputs: A is the default
// 16x32 two-port file, B is a 12-deep three-port file with out-of-range
// addresses. Both are compared against an array-based model every cycle,
// plus directed checks against literal values.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic        rsvEn;
    logic [3:0]  rsvAddr;

    logic [1:0]  rdEnA;
    logic [7:0]  rdAddrA;
    logic [63:0] rdDataA;
    logic [1:0]  rdBusyA;
    logic        busyAnyA;

    logic [2:0]  rdEnB;
    logic [11:0] rdAddrB;
    logic [95:0] rdDataB;
    logic [2:0]  rdBusyB;
    logic        busyAnyB;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays indexed [instance][register/port].
    int          depthOf [2] = '{16, 12};
    int          portsOf [2] = '{2, 3};
    logic [31:0] mReg    [2][16];
    logic        mBusy   [2][16];
    logic [31:0] expData [2][3];
    logic        expBusy [2][3];
    logic        expAny  [2];

    always #5 clk = ~clk;

    reg_file_param #(.DW(32), .DEPTH(16), .NRD(2)) dutA (
        .clk(clk), .rst(rst),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA), .rd_busy(rdBusyA),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .busy_any(busyAnyA)
    );

    reg_file_param #(.DW(32), .DEPTH(12), .NRD(3)) dutB (
        .clk(clk), .rst(rst),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .busy_any(busyAnyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                mReg[k][i]  = 32'(i);
                mBusy[k][i] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                expData[k][p] = '0;
                expBusy[k][p] = 1'b0;
            end
            expAny[k] = 1'b0;
        end
    endtask

    // One rising edge of the behavioural register file.
    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < portsOf[k]; p++) begin
                logic       en;
                logic [3:0] a;
                en = (k == 0) ? rdEnA[p] : rdEnB[p];
                a  = (k == 0) ? rdAddrA[p*4 +: 4] : rdAddrB[p*4 +: 4];
                if (en) begin
                    if (a == 0 || int'(a) >= depthOf[k]) begin
                        expData[k][p] = '0;
                        expBusy[k][p] = 1'b0;
                    end else if (BYP && wrEn && wrAddr == a) begin
                        expData[k][p] = wrData;
                        expBusy[k][p] = (rsvEn && rsvAddr == a) ? mBusy[k][a] : 1'b0;
                    end else begin
                        expData[k][p] = mReg[k][a];
                        expBusy[k][p] = mBusy[k][a];
                    end
                end
            end
            if (wrEn && wrAddr != 0 && int'(wrAddr) < depthOf[k]) begin
                mReg[k][wrAddr]  = wrData;
                mBusy[k][wrAddr] = 1'b0;
            end
            if (rsvEn && rsvAddr != 0 && int'(rsvAddr) < depthOf[k])
                mBusy[k][rsvAddr] = 1'b1;
            expAny[k] = 1'b0;
            for (int i = 0; i < depthOf[k]; i++)
                expAny[k] = expAny[k] | mBusy[k][i];
        end
    endtask

    task automatic checkAll();
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("A.rd_data[%0d]", p), rdDataA[p*32 +: 32], expData[0][p]);
            checkOutput($sformatf("A.rd_busy[%0d]", p), 32'(rdBusyA[p]), 32'(expBusy[0][p]));
        end
        for (int p = 0; p < 3; p++) begin
            checkOutput($sformatf("B.rd_data[%0d]", p), rdDataB[p*32 +: 32], expData[1][p]);
            checkOutput($sformatf("B.rd_busy[%0d]", p), 32'(rdBusyB[p]), 32'(expBusy[1][p]));
        end
        checkOutput("A.busy_any", 32'(busyAnyA), 32'(expAny[0]));
        checkOutput("B.busy_any", 32'(busyAnyB), 32'(expAny[1]));
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic rs,
                                 input logic [3:0] ra, input logic [1:0] enA,
                                 input logic [7:0] addrA, input logic [2:0] enB,
                                 input logic [11:0] addrB);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rsvEn   = rs;
        rsvAddr = ra;
        rdEnA   = enA;
        rdAddrA = addrA;
        rdEnB   = enB;
        rdAddrB = addrB;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic setIdle();
        wrEn = 0; wrAddr = 0; wrData = 0; rsvEn = 0; rsvAddr = 0;
        rdEnA = 0; rdAddrA = 0; rdEnB = 0; rdAddrB = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        setIdle();
        doReset();

        // Reset contents read back on port 0 of A.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 2'b01, {4'd0, 4'(i)}, 0, 0);
            checkOutput("reset value", rdDataA[31:0], 32'(i));
            checkOutput("reset busy", 32'(rdBusyA[0]), 32'd0);
        end

        // Write then read on port 1.
        applyStimulus(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 2'b10, {4'd5, 4'd0}, 0, 0);
        checkOutput("R5 readback", rdDataA[63:32], 32'hDEADBEEF);

        // R0 ignores writes.
        applyStimulus(1, 4'd0, 32'h1234, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 2'b01, 8'h00, 0, 0);
        checkOutput("R0 hardwired", rdDataA[31:0], 32'd0);

        // Same-edge write and read of R7.
        applyStimulus(1, 4'd7, 32'hA5A5A5A5, 0, 0, 2'b01, {4'd0, 4'd7}, 0, 0);
        checkOutput("R7 same edge", rdDataA[31:0], BYP ? 32'hA5A5A5A5 : 32'd7);

        // Reserve R3, observe busy, then retire it with a write.
        applyStimulus(0, 0, 0, 1, 4'd3, 0, 0, 0, 0);
        checkOutput("rsv busy_any", 32'(busyAnyA), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 2'b01, {4'd0, 4'd3}, 0, 0);
        checkOutput("R3 rd_busy", 32'(rdBusyA[0]), 32'd1);
        applyStimulus(1, 4'd3, 32'h55, 0, 0, 0, 0, 0, 0);
        checkOutput("clr busy_any", 32'(busyAnyA), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'b01, {4'd0, 4'd3}, 0, 0);
        checkOutput("R3 data", rdDataA[31:0], 32'h55);
        checkOutput("R3 busy clr", 32'(rdBusyA[0]), 32'd0);

        // Same-edge reserve and write: busy stays set.
        applyStimulus(1, 4'd9, 32'h99, 1, 4'd9, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 2'b01, {4'd0, 4'd9}, 0, 0);
        checkOutput("R9 data", rdDataA[31:0], 32'h99);
        checkOutput("R9 busy", 32'(rdBusyA[0]), 32'd1);

        // Out-of-range behaviour on the 12-deep instance.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b111, {4'd13, 4'd13, 4'd13});
        for (int p = 0; p < 3; p++) begin
            checkOutput("B oor data", rdDataB[p*32 +: 32], 32'd0);
            checkOutput("B oor busy", 32'(rdBusyB[p]), 32'd0);
        end
        applyStimulus(1, 4'd14, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 12; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b001, {8'd0, 4'(i)});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b111, {4'd4, 4'd4, 4'd4});
        for (int p = 0; p < 3; p++)
            checkOutput("B R4 all ports", rdDataB[p*32 +: 32], 32'd4);

        // Reset in the middle of a cycle clears outputs at once.
        applyStimulus(0, 0, 0, 0, 0, 2'b10, {4'd5, 4'd0}, 0, 0);
        #3;
        doReset();
        checkOutput("mid rst data", rdDataA[63:32], 32'd0);
        setIdle();

        // Randomised traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                          2'($urandom), 8'($urandom), 3'($urandom), 12'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
